// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-issue instruction fetch unit, one instruction in flight
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fetch_fault,
    input  logic        pc_upd_valid,
    input  logic [31:0] pc_upd,
    output logic [31:0] fetch_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_RESP     = 3'd2;
    localparam logic [2:0] S_HOLD     = 3'd3;
    localparam logic [2:0] S_WAIT_UPD = 3'd4;

    logic [2:0]  state;
    logic [31:0] tmo_cnt;
    logic [31:0] tmo_next;
    logic        tmo_hit;
    logic        aligned;

    assign aligned  = (pc[1:0] == 2'b00);
    assign tmo_next = tmo_cnt + 32'd1;
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_next == 32'(TIMEOUT));

    // Handshake strobes depend only on registered state so decode/memory never see input loops.
    assign mem_req_valid  = (state == S_REQ) && aligned;
    assign mem_addr       = pc;
    assign mem_resp_ready = (state == S_RESP);
    assign inst_valid     = (state == S_HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            inst        <= NOP_INST;
            fetch_fault <= 1'b0;
            fetch_cnt   <= 32'd0;
            tmo_cnt     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (!aligned) begin
                        inst        <= NOP_INST;
                        fetch_fault <= 1'b1;
                        state       <= S_HOLD;
                    end else if (mem_req_ready) begin
                        tmo_cnt <= 32'd0;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    // A response in the expiry cycle wins over the timeout.
                    if (mem_resp_valid) begin
                        inst        <= mem_resp_err ? NOP_INST : mem_rdata;
                        fetch_fault <= mem_resp_err;
                        state       <= S_HOLD;
                    end else begin
                        tmo_cnt <= tmo_next;
                        if (tmo_hit) begin
                            inst        <= NOP_INST;
                            fetch_fault <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        fetch_cnt <= fetch_cnt + 32'd1;
                        state     <= S_WAIT_UPD;
                    end
                end
                S_WAIT_UPD: begin
                    if (pc_upd_valid) begin
                        pc          <= pc_upd;
                        fetch_fault <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
